// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART TX packet arbiter.
//   arb_state_t    : arbiter FSM state (IDLE, LOCK)
//   *_RST          : reset values of the registered outputs
//   watchdogCntW() : width of the watchdog stall counter for a given limit
package uart_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  localparam arb_state_t STATE_RST       = IDLE;
  localparam logic       BUSY_RST        = 1'b0;
  localparam logic       TIMEOUT_ERR_RST = 1'b0;

  // Counter only has to reach cycles-1, so clog2(cycles) bits suffice (min 1).
  function automatic int unsigned watchdogCntW(input int unsigned cycles);
    int unsigned w;
    w = 1;
    if (cycles > 2) w = $clog2(cycles);
    return w;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
//   reqVec      : request vector
//   ptr         : index holding the highest priority
//   winOneHot_c : one-hot winner (0 when no request)
//   winIdx_c    : winner index
//   anyReq_c    : at least one request present
module rr_pick #(
  parameter int unsigned numReq = 4,
  parameter int unsigned idBits = 2
) (
  input  logic [numReq-1:0] reqVec,
  input  logic [idBits-1:0] ptr,
  output logic [numReq-1:0] winOneHot_c,
  output logic [idBits-1:0] winIdx_c,
  output logic              anyReq_c
);

  logic              found;
  logic [idBits-1:0] cand;

  // Scan numReq candidates starting at ptr; the first hit wins.
  always_comb begin
    winOneHot_c = '0;
    winIdx_c    = '0;
    found       = 1'b0;
    cand        = '0;
    for (int unsigned k = 0; k < numReq; k++) begin
      cand = idBits'((32'(ptr) + k) % numReq);
      if (!found && reqVec[cand]) begin
        found             = 1'b1;
        winIdx_c          = cand;
        winOneHot_c[cand] = 1'b1;
      end
    end
  end

  assign anyReq_c = |reqVec;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter owning the UART TX FIFO write port.
// A grant stays locked to one requester until its last byte is written.
// Optional watchdog release: define UART_ARB_WATCHDOG_EN.
//   clk, reset        : clock, synchronous active-high reset
//   reqValid/Last/Data: per-requester byte stream (byte i at [i*dataBits +: dataBits])
//   reqReady          : byte from requester i accepted this cycle
//   fifoF             : TX FIFO full
//   writeEn, dataOut  : TX FIFO write port (combinational from inputs)
//   grant, busy       : registered one-hot grant, lock held
//   timeoutErr, errId : watchdog release pulse and released requester index
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned dataBits      = 8,
  parameter int unsigned numReq        = 4,
  parameter int unsigned reqIdBits     = 2,
  parameter int unsigned timeoutCycles = 1024
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [numReq-1:0]            reqValid,
  input  logic [numReq-1:0]            reqLast,
  input  logic [numReq*dataBits-1:0]   reqData,
  output logic [numReq-1:0]            reqReady,
  input  logic                         fifoF,
  output logic                         writeEn,
  output logic [dataBits-1:0]          dataOut,
  output logic [numReq-1:0]            grant,
  output logic                         busy,
  output logic                         timeoutErr,
  output logic [reqIdBits-1:0]         errId
);

  if (numReq < 2 || numReq > 16 || reqIdBits != $clog2(numReq) || timeoutCycles < 2) begin : gParamCheck
    $error("uart_tx_arbiter: illegal parameter combination");
  end

  arb_state_t           state, stateNext;
  logic [numReq-1:0]    grantNext;
  logic [reqIdBits-1:0] ptr, ptrNext, gIdx, gIdxNext, ptrAfter;
  logic [numReq-1:0]    pickOneHot_c;
  logic [reqIdBits-1:0] pickIdx_c;
  logic                 pickAny_c;
  logic [dataBits-1:0]  reqBytes [numReq];

`ifdef UART_ARB_WATCHDOG_EN
  localparam int unsigned WATCHDOG_CNT_W = watchdogCntW(timeoutCycles);
  logic [WATCHDOG_CNT_W-1:0] stallCnt, stallCntNext;
  logic                      timeoutErrQ, timeoutErrNext;
  logic [reqIdBits-1:0]      errIdQ, errIdNext;
`endif

  rr_pick #(.numReq(numReq), .idBits(reqIdBits)) uPick (
    .reqVec      (reqValid),
    .ptr         (ptr),
    .winOneHot_c (pickOneHot_c),
    .winIdx_c    (pickIdx_c),
    .anyReq_c    (pickAny_c)
  );

  // Unpack the flat data bus into per-requester bytes.
  always_comb begin
    for (int unsigned k = 0; k < numReq; k++) begin
      reqBytes[k] = reqData[k*dataBits +: dataBits];
    end
  end

  // Priority moves to the requester after the one just released.
  assign ptrAfter = (gIdx == reqIdBits'(numReq - 1)) ? '0 : gIdx + reqIdBits'(1);

  // Next-state and write-port logic.
  always_comb begin
    stateNext = state;
    grantNext = grant;
    ptrNext   = ptr;
    gIdxNext  = gIdx;
    reqReady  = '0;
    writeEn   = 1'b0;
    dataOut   = '0;
`ifdef UART_ARB_WATCHDOG_EN
    stallCntNext   = stallCnt;
    timeoutErrNext = TIMEOUT_ERR_RST;
    errIdNext      = errIdQ;
`endif
    case (state)
      IDLE: begin
        if (pickAny_c) begin
          stateNext = LOCK;
          grantNext = pickOneHot_c;
          gIdxNext  = pickIdx_c;
`ifdef UART_ARB_WATCHDOG_EN
          stallCntNext = '0;
`endif
        end
      end
      LOCK: begin
        reqReady[gIdx] = ~fifoF;
        writeEn        = reqValid[gIdx] & ~fifoF;
        dataOut        = reqBytes[gIdx];
        if (writeEn && reqLast[gIdx]) begin
          stateNext = IDLE;
          grantNext = '0;
          ptrNext   = ptrAfter;
        end
`ifdef UART_ARB_WATCHDOG_EN
        // Only an absent requester counts as stalled; FIFO-full stalls do not.
        else if (reqValid[gIdx]) begin
          stallCntNext = '0;
        end else if (stallCnt == WATCHDOG_CNT_W'(timeoutCycles - 1)) begin
          stateNext      = IDLE;
          grantNext      = '0;
          ptrNext        = ptrAfter;
          timeoutErrNext = 1'b1;
          errIdNext      = gIdx;
        end else begin
          stallCntNext = stallCnt + WATCHDOG_CNT_W'(1);
        end
`endif
      end
      default: stateNext = STATE_RST;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= STATE_RST;
      grant <= '0;
      ptr   <= '0;
      gIdx  <= '0;
    end else begin
      state <= stateNext;
      grant <= grantNext;
      ptr   <= ptrNext;
      gIdx  <= gIdxNext;
    end
  end

  assign busy = (state == LOCK) ? 1'b1 : BUSY_RST;

`ifdef UART_ARB_WATCHDOG_EN
  // Watchdog registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      stallCnt    <= '0;
      timeoutErrQ <= TIMEOUT_ERR_RST;
      errIdQ      <= '0;
    end else begin
      stallCnt    <= stallCntNext;
      timeoutErrQ <= timeoutErrNext;
      errIdQ      <= errIdNext;
    end
  end

  assign timeoutErr = timeoutErrQ;
  assign errId      = errIdQ;
`else
  assign timeoutErr = TIMEOUT_ERR_RST;
  assign errId      = '0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus random
// traffic, all compared against a transaction-level model of the arbiter.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  localparam int NUM = 4;
  localparam int DB  = 8;
  localparam int IDB = 2;
  localparam int TO  = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [NUM-1:0]    reqValid, reqLast, reqReady, grant;
  logic [NUM*DB-1:0] reqData;
  logic              fifoF, writeEn, busy, timeoutErr;
  logic [DB-1:0]     dataOut;
  logic [IDB-1:0]    errId;

  uart_tx_arbiter #(.dataBits(DB), .numReq(NUM), .reqIdBits(IDB), .timeoutCycles(TO)) dut (
    .clk(clk), .reset(reset), .reqValid(reqValid), .reqLast(reqLast), .reqData(reqData),
    .reqReady(reqReady), .fifoF(fifoF), .writeEn(writeEn), .dataOut(dataOut),
    .grant(grant), .busy(busy), .timeoutErr(timeoutErr), .errId(errId)
  );

  always #5 clk = ~clk;

  // Sources: per-requester byte queues, bit 8 = last.
  logic [8:0] srcQ [NUM][$];
  bit         mute [NUM];
  int         validPct, fifoPct;
  bit         fifoForce, rstNow;

  // Observed write log.
  logic [7:0] wrByte[$];
  int         wrCyc[$];
  int         toSeen;

  int errors, checks, cyc;

  // Model: current owner (-1 = none), priority pointer, stall count.
  int ow, p, stall, expErr;
  bit expTo;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic pushByte(input int r, input logic [7:0] d, input bit last);
    srcQ[r].push_back({last, d});
  endtask

  function automatic bit allEmpty();
    bit e;
    e = 1'b1;
    for (int i = 0; i < NUM; i++) if (srcQ[i].size() != 0) e = 1'b0;
    return e;
  endfunction

  task automatic clearLog();
    wrByte.delete();
    wrCyc.delete();
    toSeen = 0;
  endtask

  task automatic runCycle();
    logic [NUM-1:0] vld, lst, eGrant, eReady;
    logic [7:0]     dat [NUM];
    logic [8:0]     h;
    logic           eWe, ff;
    logic [7:0]     eData;
    @(negedge clk);
    for (int i = 0; i < NUM; i++) begin
      if (srcQ[i].size() > 0) begin
        h      = srcQ[i][0];
        dat[i] = h[7:0];
        lst[i] = h[8];
        vld[i] = !mute[i] && !rstNow && (int'($urandom_range(99)) < validPct);
      end else begin
        dat[i] = 8'($urandom);
        lst[i] = 1'($urandom);
        vld[i] = 1'b0;
      end
      reqData[i*DB +: DB] = dat[i];
    end
    ff       = fifoForce | (int'($urandom_range(99)) < fifoPct);
    fifoF    = ff;
    reqValid = vld;
    reqLast  = lst;
    reset    = rstNow;
    #1;
    eGrant = '0; eReady = '0; eWe = 1'b0; eData = '0;
    if (ow >= 0) begin
      eGrant[ow] = 1'b1;
      eReady[ow] = !ff;
      eWe        = vld[ow] && !ff;
      eData      = dat[ow];
    end
    checkEq("grant", grant, eGrant);
    checkEq("busy", busy, ow >= 0);
    checkEq("reqReady", reqReady, eReady);
    checkEq("writeEn", writeEn, eWe);
    checkEq("dataOut", dataOut, eData);
    checkEq("timeoutErr", timeoutErr, expTo);
    checkEq("errId", errId, expErr);
    if (writeEn === 1'b1) begin
      wrByte.push_back(dataOut);
      wrCyc.push_back(cyc);
    end
    if (timeoutErr === 1'b1) toSeen++;
    for (int i = 0; i < NUM; i++) if (vld[i] && eReady[i]) void'(srcQ[i].pop_front());
    expTo = 1'b0;
    if (rstNow) begin
      ow = -1; p = 0; stall = 0; expErr = 0;
    end else if (ow < 0) begin
      for (int k = 0; k < NUM; k++) begin
        if (ow < 0 && vld[(p + k) % NUM]) begin
          ow    = (p + k) % NUM;
          stall = 0;
        end
      end
    end else if (eWe && lst[ow]) begin
      p  = (ow + 1) % NUM;
      ow = -1;
    end
`ifdef UART_ARB_WATCHDOG_EN
    else if (vld[ow]) stall = 0;
    else if (stall == TO - 1) begin
      expTo  = 1'b1;
      expErr = ow;
      p      = (ow + 1) % NUM;
      ow     = -1;
    end else stall++;
`endif
    cyc++;
  endtask

  task automatic drain(input int budget, input string tag);
    int n;
    n = 0;
    while ((!allEmpty() || ow >= 0) && n < budget) begin
      runCycle();
      n++;
    end
    checkEq(tag, 32'(allEmpty() && ow < 0), 32'd1);
  endtask

  initial begin
    int start, pushed, len, r;
    errors = 0; checks = 0; cyc = 0;
    ow = -1; p = 0; stall = 0; expErr = 0; expTo = 1'b0;
    for (int i = 0; i < NUM; i++) mute[i] = 1'b0;
    validPct = 100; fifoPct = 0; fifoForce = 1'b0; rstNow = 1'b0;
    reset = 1'b1; reqValid = '0; reqLast = '0; reqData = '0; fifoF = 1'b0;
    repeat (3) @(posedge clk);

    // Reset state, then all four requesters with two 2-byte packets each.
    clearLog();
    for (int rr = 0; rr < 2; rr++)
      for (int i = 0; i < NUM; i++)
        for (int b = 0; b < 2; b++) pushByte(i, 8'(16*i + 4*rr + b), b == 1);
    drain(200, "D_drain");
    checkEq("D_count", wrByte.size(), 16);
    for (int k = 0; k < wrByte.size() && k < 16; k++) begin
      checkEq("D_byte", wrByte[k], 8'(16*((k/2)%4) + 4*(k/8) + (k%2)));
      if (k > 0) checkEq("D_gap", wrCyc[k] - wrCyc[k-1], (k % 2 == 1) ? 1 : 2);
    end

    // Requester 1 sends 0x41,0x42,0x43.
    clearLog();
    pushByte(1, 8'h41, 0); pushByte(1, 8'h42, 0); pushByte(1, 8'h43, 1);
    start = cyc;
    drain(50, "B_drain");
    runCycle();
    checkEq("B_count", wrByte.size(), 3);
    if (wrByte.size() == 3) begin
      checkEq("B_b0", wrByte[0], 8'h41);
      checkEq("B_b1", wrByte[1], 8'h42);
      checkEq("B_b2", wrByte[2], 8'h43);
      checkEq("B_lat", wrCyc[0] - start, 1);
      checkEq("B_span", wrCyc[2] - wrCyc[0], 2);
    end

    // Single-byte packet from 3 while 0 waits; ptr wraps to 0.
    clearLog();
    pushByte(3, 8'hC3, 1);
    pushByte(0, 8'hD0, 0); pushByte(0, 8'hD1, 1);
    drain(50, "C_drain");
    checkEq("C_count", wrByte.size(), 3);
    if (wrByte.size() == 3) begin
      checkEq("C_first", wrByte[0], 8'hC3);
      checkEq("C_second", wrByte[1], 8'hD0);
      checkEq("C_bubble", wrCyc[1] - wrCyc[0], 2);
    end

    // FIFO full for 5 cycles in the middle of requester 2's packet.
    clearLog();
    for (int b = 0; b < 4; b++) pushByte(2, 8'hE0 + 8'(b), b == 3);
    repeat (3) runCycle();
    fifoForce = 1'b1;
    repeat (5) runCycle();
    fifoForce = 1'b0;
    drain(50, "E_drain");
    checkEq("E_count", wrByte.size(), 4);
    if (wrByte.size() == 4) begin
      for (int b = 0; b < 4; b++) checkEq("E_byte", wrByte[b], 8'hE0 + 8'(b));
      checkEq("E_stall", wrCyc[2] - wrCyc[1], 6);
    end

    // Reset on the second byte of requester 3's packet; ptr must restart at 0.
    for (int b = 0; b < 4; b++) pushByte(3, 8'hF0 + 8'(b), b == 3);
    repeat (2) runCycle();
    rstNow = 1'b1;
    runCycle();
    rstNow = 1'b0;
    srcQ[3].delete();
    clearLog();
    pushByte(1, 8'h11, 1);
    pushByte(3, 8'h33, 1);
    drain(50, "F_drain");
    checkEq("F_count", wrByte.size(), 2);
    if (wrByte.size() == 2) begin
      checkEq("F_first", wrByte[0], 8'h11);
      checkEq("F_second", wrByte[1], 8'h33);
    end

`ifdef UART_ARB_WATCHDOG_EN
    // Requester 0 stalls mid-packet; watchdog releases it and 1 is granted.
    begin
      int n;
      clearLog();
      pushByte(0, 8'hA0, 0); pushByte(0, 8'hA1, 1);
      pushByte(1, 8'hB0, 1);
      repeat (2) runCycle();
      mute[0] = 1'b1;
      n = 0;
      while (wrByte.size() < 2 && n < 30) begin
        runCycle();
        n++;
      end
      checkEq("H_written", wrByte.size(), 2);
      if (wrByte.size() == 2) begin
        checkEq("H_next", wrByte[1], 8'hB0);
        checkEq("H_gap", wrCyc[1] - wrCyc[0], 10);
      end
      checkEq("H_pulses", toSeen, 1);
      checkEq("H_errId", errId, 0);
      mute[0] = 1'b0;
      drain(50, "H_drain");
    end
`endif

    // Random traffic with random valid gaps and FIFO backpressure.
    clearLog();
    pushed = 0;
    validPct = 80; fifoPct = 25;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(3) == 0) begin
        r = int'($urandom_range(NUM - 1));
        if (srcQ[r].size() < 12) begin
          len = int'($urandom_range(1, 4));
          for (int b = 0; b < len; b++) pushByte(r, 8'($urandom), b == len - 1);
          pushed += len;
        end
      end
      runCycle();
    end
    validPct = 100; fifoPct = 0;
    drain(2000, "G_drain");
    checkEq("G_count", wrByte.size(), pushed);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Packet-level round-robin arbiter that shares the UART transmit FIFO among `numReq` byte-stream requesters. It sits in front of the TX FIFO write port (`writeEn`/`dataIn`) and owns it exclusively. A grant is locked to one requester from its first byte until its `last` byte is accepted, so packets never interleave on the serial line. FIFO-full backpressure is honoured without dropping bytes.

## Interface

Parameters:
- `dataBits`, 8, byte width; matches the TX FIFO.
- `numReq`, 4, number of requesters; legal range 2..16.
- `reqIdBits`, 2, width of the requester index; equals `$clog2(numReq)`.
- `timeoutCycles`, 1024, watchdog limit in cycles; used only with `UART_ARB_WATCHDOG_EN`.

Ports:
- `clk`, in, 1, single clock.
- `reset`, in, 1, synchronous, active-high.
- `reqValid`, in, numReq, requester i presents a byte.
- `reqLast`, in, numReq, the presented byte ends requester i's packet.
- `reqData`, in, numReq*dataBits, requester i's byte at `[i*dataBits +: dataBits]`.
- `reqReady`, out, numReq, the byte from requester i is accepted this cycle when its `reqValid` is also high.
- `fifoF`, in, 1, TX FIFO full.
- `writeEn`, out, 1, TX FIFO write strobe.
- `dataOut`, out, dataBits, byte written to the TX FIFO.
- `grant`, out, numReq, one-hot registered grant.
- `busy`, out, 1, high while a packet lock is held.
- `timeoutErr`, out, 1, one-cycle pulse on watchdog release.
- `errId`, out, reqIdBits, index of the requester released by the watchdog.

## Operation

- The FSM has two states: IDLE and LOCK.
- IDLE:
  - If any `reqValid` is high, pick the first requester at or after the priority pointer `ptr`, wrapping modulo `numReq`.
  - Register `grant` to that one-hot value and go to LOCK.
  - If no `reqValid` is high, stay in IDLE.
- LOCK, with granted index g:
  - `reqReady[g] = ~fifoF`. All other `reqReady` bits are 0.
  - `writeEn = reqValid[g] & ~fifoF`.
  - `dataOut = reqData[g]` whenever in LOCK, and 0 in IDLE.
  - When `writeEn` is high and `reqLast[g]` is high, go to IDLE, clear `grant`, and set `ptr` to (g+1) mod `numReq`.
- A single-byte packet has `reqLast` high on its first byte. It is legal and takes one LOCK cycle.
- `reqValid` dropping mid-packet does not release the lock; the grant persists.
- `fifoF` high stalls the transfer. No byte is lost or duplicated, and the lock is held.
- `busy` equals (state == LOCK).
- `reset` asserted in any state, including mid-packet:
  - Next cycle the state is IDLE and `ptr` is 0.
  - `grant`, `busy`, `timeoutErr` and `errId` are 0.
  - The partially sent packet stays in the FIFO. The requester is responsible for re-framing.
- Reset values: `grant`=0, `busy`=0, `reqReady`=0, `writeEn`=0, `dataOut`=0, `timeoutErr`=0, `errId`=0.

## Timing

- Arbitration latency: a request seen in IDLE at cycle n gets its grant registered at n+1. The earliest FIFO write is at n+1.
- The write path is combinational from `reqValid`/`fifoF`/`reqData` to `writeEn`/`dataOut`. All state, including `grant` and `ptr`, is registered.
- Sustained throughput is 1 byte/cycle within a packet while `fifoF` is low.
- There is one idle bubble cycle between consecutive packets, including back-to-back packets from the same requester.
- Fairness: with all requesters continuously valid, packets are granted in the order 0,1,2,…,numReq-1,0,…
- `fifoF` must reflect writes from the previous cycle; this matches standard FIFO full timing.

## Configuration

- `UART_ARB_WATCHDOG_EN` defined:
  - Counter `stallCnt` is active in LOCK.
  - It increments on cycles with `reqValid[g]`=0.
  - It clears on any cycle with `reqValid[g]`=1, and on entry to LOCK.
  - Cycles stalled only by `fifoF` do not count.
  - When `stallCnt` reaches `timeoutCycles-1` and `reqValid[g]` is still 0, the FSM goes to IDLE, `ptr` becomes g+1, `timeoutErr` pulses for 1 cycle, and `errId` is set to g (held until the next error).
- `UART_ARB_WATCHDOG_EN` undefined: no counter logic; `timeoutErr` and `errId` are tied to 0; the lock is held indefinitely.

## Structure

- Shared package `uart_arb_pkg` holds:
  - the state enum `arb_state_t` (IDLE, LOCK);
  - the reset-value constants;
  - a `WATCHDOG_CNT_W` derivation function.
- One sub-module, `rr_pick`: combinational round-robin picker.
  - Inputs: request vector and `ptr`.
  - Outputs: one-hot winner and its index.
  - It is reusable by other shared-resource controllers.

## Test plan

- Single requester 1 sends 3 bytes 0x41,0x42,0x43 (last on 0x43) → grant=0b0010 one cycle after valid; `dataOut` is 0x41,0x42,0x43 on 3 consecutive `writeEn` cycles; `busy` falls after the third.
- All 4 requesters valid with 2-byte packets → packet order 0,1,2,3,0; bytes are never interleaved; there is exactly 1 idle cycle between packets.
- `fifoF` held high for 5 cycles in the middle of requester 2's 4-byte packet → `writeEn`=0 and `reqReady[2]`=0 during the stall; all 4 bytes are written exactly once, in order.
- `reset` pulsed on the second byte of a 4-byte packet → next cycle `grant`=0, `busy`=0, `ptr`=0; a new request from requester 3 is granted normally afterwards.
- With `UART_ARB_WATCHDOG_EN` and `timeoutCycles`=8: requester 0 sends 1 byte without last, then drops valid → after 8 stall cycles `timeoutErr` pulses, `errId`=0, and the pending requester 1 is granted next.
- Single-byte packet (last on the first byte) from requester 3 while requester 0 is waiting → requester 3 is written in 1 cycle, then after the bubble requester 0 is granted because `ptr` wrapped to 0.
